// File: rtl/bus_mux_pipe.sv
// bus_mux_pipe: registered datapath bus multiplexer with bus keeper,
// select-conflict detection and a saturating conflict counter.
//
// Sources are chosen with fixed priority DIN > G > R. The bus value and
// status are captured on the rising edge of Clock, so there is one cycle
// of latency and no combinational path from inputs to outputs.
//
// Ports:
//   Clock      rising-edge clock
//   Resetn     synchronous active-low reset
//   Rout       one-hot register select (bit NREGS-1 -> R0, bit 0 -> R(NREGS-1))
//   Gout       select ALU result Gdata
//   DINout     select external DINdata
//   Rdata      flattened register outputs, Ri = Rdata[i*WIDTH +: WIDTH]
//   Gdata      ALU result
//   DINdata    external data input
//   Err_clr    synchronous clear of Sel_err and Err_count
//   BusWires   registered bus value
//   Bus_valid  bus was loaded from a legal source on the last edge
//   Last_src   last legal source ID: 0..NREGS-1 = Ri, NREGS = G, NREGS+1 = DIN
//   Sel_err    sticky select-conflict flag
//   Err_count  saturating count of conflict cycles
//
// Build option:
//   BUS_MUX_ZERO_IDLE_EN  when defined, idle and Rout-only conflict cycles
//                         load zero onto the bus instead of holding it.

module bus_mux_pipe #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NREGS    = 8,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                          Clock,
  input  logic                          Resetn,
  input  logic [NREGS-1:0]              Rout,
  input  logic                          Gout,
  input  logic                          DINout,
  input  logic [NREGS*WIDTH-1:0]        Rdata,
  input  logic [WIDTH-1:0]              Gdata,
  input  logic [WIDTH-1:0]              DINdata,
  input  logic                          Err_clr,
  output logic [WIDTH-1:0]              BusWires,
  output logic                          Bus_valid,
  output logic [$clog2(NREGS+2)-1:0]    Last_src,
  output logic                          Sel_err,
  output logic [ERRCNT_W-1:0]           Err_count
);

  localparam int unsigned SRC_W = $clog2(NREGS + 2);

  logic [WIDTH-1:0]    bus_q,   bus_d;
  logic                valid_q, valid_d;
  logic [SRC_W-1:0]    src_q,   src_d;
  logic                sel_q,   sel_d;
  logic [ERRCNT_W-1:0] cnt_q,   cnt_d;

  logic             r_any;
  logic             r_multi;
  logic             conflict;
  logic [WIDTH-1:0] r_data;
  logic [SRC_W-1:0] r_id;

  // Register-select decode; x & (x-1) is nonzero iff two or more bits are set.
  always_comb begin
    r_any   = |Rout;
    r_multi = |(Rout & (Rout - NREGS'(1)));
    r_data  = '0;
    r_id    = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      if (Rout[int'(NREGS) - 1 - i]) begin
        r_data = Rdata[i*WIDTH +: WIDTH];
        r_id   = SRC_W'(i);
      end
    end
    conflict = (DINout & Gout) | ((DINout | Gout) & r_any) | r_multi;
  end

  // Next-state for bus, source tracking and error bookkeeping.
  always_comb begin
    bus_d   = bus_q;
    src_d   = src_q;
    valid_d = 1'b0;
    sel_d   = sel_q;
    cnt_d   = cnt_q;

    if (DINout) begin
      bus_d   = DINdata;
      src_d   = SRC_W'(NREGS + 1);
      valid_d = 1'b1;
    end else if (Gout) begin
      bus_d   = Gdata;
      src_d   = SRC_W'(NREGS);
      valid_d = 1'b1;
    end else if (r_any && !r_multi) begin
      bus_d   = r_data;
      src_d   = r_id;
      valid_d = 1'b1;
    end else begin
`ifdef BUS_MUX_ZERO_IDLE_EN
      bus_d = '0;
`else
      bus_d = bus_q;
`endif
    end

    // Clear takes precedence over a conflict in the same cycle.
    if (Err_clr) begin
      sel_d = 1'b0;
      cnt_d = '0;
    end else if (conflict) begin
      sel_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + ERRCNT_W'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      bus_q   <= '0;
      valid_q <= 1'b0;
      src_q   <= '0;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      bus_q   <= bus_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign BusWires  = bus_q;
  assign Bus_valid = valid_q;
  assign Last_src  = src_q;
  assign Sel_err   = sel_q;
  assign Err_count = cnt_q;

endmodule
